// File: rtl/store_merge_rmw_pkg.sv
// Shared definitions for the store merge / read-modify-write block.
// Contents:
//   TAM_BYTE/TAM_HALF/TAM_WORD - store size encodings (2'b11 is reserved)
//   state_t                    - FSM state encoding
//   is_misaligned()            - alignment/legality check for a request
package store_merge_rmw_pkg;

  localparam logic [1:0] TAM_BYTE = 2'b00;
  localparam logic [1:0] TAM_HALF = 2'b01;
  localparam logic [1:0] TAM_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LEER     = 3'd1,
    ESPERA   = 3'd2,
    ESCRIBIR = 3'd3,
    FIN      = 3'd4
  } state_t;

  // Reserved size codes are reported the same way as misaligned ones.
  function automatic logic is_misaligned(input logic [1:0] tam, input logic [1:0] lane);
    logic bad;
    case (tam)
      TAM_BYTE: bad = 1'b0;
      TAM_HALF: bad = lane[0];
      TAM_WORD: bad = (lane != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_merge_rmw_lane_merge.sv
// Combinational little-endian lane merge: inserts the low byte/halfword of
// dato_i into old_i at byte lane lane_i, or replaces the whole word.
// Ports:
//   old_i    [31:0] word currently in memory
//   dato_i   [31:0] register value being stored (low lane used for byte/half)
//   tamano_i [1:0]  store size
//   lane_i   [1:0]  byte offset within the word
//   merged_o [31:0] word to write back
module store_merge_rmw_lane_merge
  import store_merge_rmw_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] dato_i,
  input  logic [1:0]  tamano_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    case (tamano_i)
      TAM_BYTE: merged_o[{lane_i, 3'b000} +: 8] = dato_i[7:0];
      // Halfword lanes are 0 or 2; only lane_i[1] selects the half.
      TAM_HALF: merged_o[{lane_i[1], 4'b0000} +: 16] = dato_i[15:0];
      TAM_WORD: merged_o = dato_i;
      default:  merged_o = old_i;
    endcase
  end

endmodule

// File: rtl/store_merge_rmw.sv
// Store path between the datapath store port and word-organised data memory.
// Word stores are written directly; byte/half stores read the containing
// word, merge the new lane and write it back. Illegal requests finish with
// an error pulse and no memory access.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              store request, accepted only in IDLE
//   Direccion [ADDR_W] byte address;  Dato [32] value;  Tamano [2] size
//   busy               high whenever the FSM is not in IDLE
//   done, error        one-cycle completion pulse / error flag with done
//   mem_addr           word-aligned memory address
//   mem_rd_en/mem_rdata  read strobe / read data (READ_LAT cycles later)
//   mem_wr_en/mem_wdata  write strobe / merged write word
//   dbg_state_o        current FSM state for observation
//
// Handshake: a request is taken on a rising edge where start = 1 and busy = 0.
// busy then stays high until the cycle after the done pulse; start is ignored
// throughout, including in the done cycle. There is no backpressure from the
// memory: it must return mem_rdata exactly READ_LAT cycles after mem_rd_en.
module store_merge_rmw
  import store_merge_rmw_pkg::*;
#(
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] Direccion,
  input  logic [31:0]       Dato,
  input  logic [1:0]        Tamano,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        dbg_state_o
);

  localparam int unsigned CNT_W = 2;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          lane_q, lane_d;
  logic [31:0]         dato_q, dato_d;
  logic [1:0]          tam_q, tam_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [31:0]         merged;

  store_merge_rmw_lane_merge u_lane_merge (
    .old_i    (mem_rdata),
    .dato_i   (dato_q),
    .tamano_i (tam_q),
    .lane_i   (lane_q),
    .merged_o (merged)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    dato_d  = dato_q;
    tam_d   = tam_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = {Direccion[ADDR_W-1:2], 2'b00};
          lane_d = Direccion[1:0];
          dato_d = Dato;
          tam_d  = Tamano;
          if (is_misaligned(Tamano, Direccion[1:0])) begin
            state_d = FIN;
            err_d   = 1'b1;
          end else if (Tamano == TAM_WORD) begin
            state_d = ESCRIBIR;
            wdata_d = Dato;
          end else begin
            state_d = LEER;
          end
        end
      end
      LEER: begin
        state_d = ESPERA;
        cnt_d   = CNT_W'(READ_LAT - 1);
      end
      ESPERA: begin
        // mem_rdata is valid only in the last ESPERA cycle; merge it there.
        if (cnt_q == '0) begin
          state_d = ESCRIBIR;
          wdata_d = merged;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ESCRIBIR: state_d = FIN;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Strobes are decoded from the next state so they register with it.
    rd_d   = (state_d == LEER);
    wr_d   = (state_d == ESCRIBIR);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lane_q  <= '0;
      dato_q  <= '0;
      tam_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      dato_q  <= dato_d;
      tam_q   <= tam_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign error       = err_q;
  assign mem_addr    = addr_q;
  assign mem_rd_en   = rd_q;
  assign mem_wr_en   = wr_q;
  assign mem_wdata   = wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_store_merge_rmw.sv
// Bench for store_merge_rmw: one instance with READ_LAT = 1 (A) and one with
// READ_LAT = 3 (B), each with a small memory model returning a fixed word.
module tb_store_merge_rmw;
  import store_merge_rmw_pkg::*;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] dir = '0, dato = '0;
  logic [1:0]  tam = '0;
  logic [31:0] mem_word = '0;

  logic        a_busy, a_done, a_err, a_rd, a_wr;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [2:0]  a_state;
  logic        b_busy, b_done, b_err, b_rd, b_wr;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [2:0]  b_state;

  store_merge_rmw #(.READ_LAT(LAT_A), .ADDR_W(32)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .Direccion(dir), .Dato(dato),
    .Tamano(tam), .busy(a_busy), .done(a_done), .error(a_err),
    .mem_addr(a_addr), .mem_rd_en(a_rd), .mem_rdata(a_rdata),
    .mem_wr_en(a_wr), .mem_wdata(a_wdata), .dbg_state_o(a_state)
  );

  store_merge_rmw #(.READ_LAT(LAT_B), .ADDR_W(32)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .Direccion(dir), .Dato(dato),
    .Tamano(tam), .busy(b_busy), .done(b_done), .error(b_err),
    .mem_addr(b_addr), .mem_rd_en(b_rd), .mem_rdata(b_rdata),
    .mem_wr_en(b_wr), .mem_wdata(b_wdata), .dbg_state_o(b_state)
  );

  // Memory model: data valid exactly LAT cycles after the read strobe,
  // garbage otherwise so a mistimed capture corrupts the merge.
  logic [3:0] a_pipe = '0, b_pipe = '0;
  always @(posedge clk) begin
    a_pipe <= {a_pipe[2:0], a_rd};
    b_pipe <= {b_pipe[2:0], b_rd};
  end
  assign a_rdata = a_pipe[LAT_A-1] ? mem_word : 32'hA5A5_A5A5;
  assign b_rdata = b_pipe[LAT_B-1] ? mem_word : 32'hA5A5_A5A5;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q_a[$];
  logic [63:0] exp_q_b[$];
  logic [63:0] e_a, e_b;

  always @(negedge clk) begin
    if (a_wr === 1'b1) begin
      if (exp_q_a.size() == 0) check("a_unexpected_write", {a_addr, a_wdata}, 64'h0);
      else begin
        e_a = exp_q_a.pop_front();
        check("a_write", {a_addr, a_wdata}, e_a);
      end
    end
    if (b_wr === 1'b1) begin
      if (exp_q_b.size() == 0) check("b_unexpected_write", {b_addr, b_wdata}, 64'h0);
      else begin
        e_b = exp_q_b.pop_front();
        check("b_write", {b_addr, b_wdata}, e_b);
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] dato;
    logic [1:0]  tam;
    logic [31:0] memw;
    logic [31:0] exp_wdata;
    logic        exp_err;
    int          exp_lat;   // for READ_LAT = 1
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  // Caller is at a negedge with the selected DUT idle. Returns at the
  // negedge of the IDLE cycle that follows done.
  task automatic do_store(input bit sel, input vec_t v, input int exp_lat,
                          input bit hold, input string tag);
    logic [31:0] exp_addr, rd_addr, s_addr;
    logic s_busy, s_rd, s_wr, s_done, s_err;
    int lat, nrd, nwr;
    bit got_done, overlap, bad_busy, stray_err;
    logic err_seen;
    exp_addr = {v.addr[31:2], 2'b00};
    rd_addr = '0; lat = 0; nrd = 0; nwr = 0;
    got_done = 0; overlap = 0; bad_busy = 0; stray_err = 0; err_seen = 1'b0;
    mem_word = v.memw;
    dir = v.addr; dato = v.dato; tam = v.tam;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    if (v.exp_wr != 0) begin
      if (sel) exp_q_b.push_back({exp_addr, v.exp_wdata});
      else exp_q_a.push_back({exp_addr, v.exp_wdata});
    end
    @(posedge clk);
    #1;
    if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
    for (int c = 1; c <= 20 && !got_done; c++) begin
      @(negedge clk);
      s_busy = sel ? b_busy : a_busy;
      s_rd   = sel ? b_rd   : a_rd;
      s_wr   = sel ? b_wr   : a_wr;
      s_done = sel ? b_done : a_done;
      s_err  = sel ? b_err  : a_err;
      s_addr = sel ? b_addr : a_addr;
      if (s_busy !== 1'b1) bad_busy = 1;
      if (s_rd === 1'b1 && s_wr === 1'b1) overlap = 1;
      if (s_rd === 1'b1) begin nrd++; rd_addr = s_addr; end
      if (s_wr === 1'b1) nwr++;
      if (s_err === 1'b1 && s_done !== 1'b1) stray_err = 1;
      if (s_done === 1'b1) begin got_done = 1; lat = c; err_seen = s_err; end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_error"}, 64'(err_seen), 64'(v.exp_err));
    check({tag, "_rd_count"}, 64'(nrd), 64'(v.exp_rd));
    check({tag, "_wr_count"}, 64'(nwr), 64'(v.exp_wr));
    check({tag, "_strobe_overlap"}, 64'(overlap), 64'h0);
    check({tag, "_error_without_done"}, 64'(stray_err), 64'h0);
    check({tag, "_busy_during_op"}, 64'(bad_busy), 64'h0);
    if (v.exp_rd != 0) check({tag, "_rd_addr"}, 64'(rd_addr), 64'(exp_addr));
    @(negedge clk);
    s_busy = sel ? b_busy : a_busy;
    s_done = sel ? b_done : a_done;
    check({tag, "_idle_after_done"}, {62'h0, s_busy, s_done}, 64'h0);
  endtask

  // ---------------- main test ----------------
  vec_t vh, vr;
  int nwr_after;

  initial begin
    //            addr          dato          tam       memw          exp_wdata     err lat rd wr
    vecs[0]  = '{32'h0000_0101, 32'hFFFF_FFAB, TAM_BYTE, 32'h1122_3344, 32'h1122_AB44, 1'b0, 4, 1, 1};
    vecs[1]  = '{32'h0000_0202, 32'h0000_1234, TAM_HALF, 32'hDEAD_BEEF, 32'h1234_BEEF, 1'b0, 4, 1, 1};
    vecs[2]  = '{32'h0000_0300, 32'hCAFE_F00D, TAM_WORD, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 2, 0, 1};
    vecs[3]  = '{32'h0000_0203, 32'h0000_5555, TAM_HALF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 0};
    vecs[4]  = '{32'h0000_0302, 32'h1234_5678, TAM_WORD, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 0};
    vecs[5]  = '{32'h0000_0400, 32'h1234_5678, TAM_BYTE, 32'hAABB_CCDD, 32'hAABB_CC78, 1'b0, 4, 1, 1};
    vecs[6]  = '{32'h0000_0403, 32'h0000_00EE, TAM_BYTE, 32'h0102_0304, 32'hEE02_0304, 1'b0, 4, 1, 1};
    vecs[7]  = '{32'h0000_0402, 32'h0000_005A, TAM_BYTE, 32'hFFFF_FFFF, 32'hFF5A_FFFF, 1'b0, 4, 1, 1};
    vecs[8]  = '{32'h0000_0500, 32'hFFFF_8001, TAM_HALF, 32'h1122_3344, 32'h1122_8001, 1'b0, 4, 1, 1};
    vecs[9]  = '{32'h0000_0600, 32'h0000_0001, 2'b11,    32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 0};
    vecs[10] = '{32'h0000_0701, 32'h0000_0001, TAM_WORD, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 0};
    vecs[11] = '{32'h0000_0201, 32'h0000_0001, TAM_HALF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 0};
    vecs[12] = '{32'hFFFF_FFFC, 32'h0000_0000, TAM_WORD, 32'h1111_1111, 32'h0000_0000, 1'b0, 2, 0, 1};
    vecs[13] = '{32'hFFFF_FFFF, 32'h0000_0099, TAM_BYTE, 32'h0000_0000, 32'h9900_0000, 1'b0, 4, 1, 1};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset_a_ctrl", {59'h0, a_busy, a_done, a_err, a_rd, a_wr}, 64'h0);
    check("reset_a_data", {a_addr, a_wdata}, 64'h0);
    check("reset_b_ctrl", {59'h0, b_busy, b_done, b_err, b_rd, b_wr}, 64'h0);
    check("reset_b_data", {b_addr, b_wdata}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table on both latencies; byte/half latency is 3 + READ_LAT.
    for (int i = 0; i < NV; i++)
      do_store(1'b0, vecs[i], vecs[i].exp_lat, 1'b0, $sformatf("a_v%0d", i));
    for (int i = 0; i < NV; i++)
      do_store(1'b1, vecs[i], vecs[i].exp_lat + ((vecs[i].exp_rd != 0) ? 2 : 0),
               1'b0, $sformatf("b_v%0d", i));

    // Reset during ESPERA aborts the store with no later write.
    vr = vecs[0];
    mem_word = vr.memw; dir = vr.addr; dato = vr.dato; tam = vr.tam;
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(posedge clk); #2;
    check("rst_mid_state_before", 64'(a_state), 64'(ESPERA));
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {59'h0, a_busy, a_done, a_err, a_rd, a_wr}, 64'h0);
    check("rst_mid_data", {a_addr, a_wdata}, 64'h0);
    check("rst_mid_state", 64'(a_state), 64'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nwr_after = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_wr === 1'b1 || a_busy === 1'b1) nwr_after++;
    end
    check("rst_mid_no_activity_after", 64'(nwr_after), 64'h0);
    do_store(1'b0, vecs[5], 4, 1'b0, "a_after_rst");

    // start held high through a whole READ_LAT = 3 store: exactly one
    // operation, then the next is taken only from IDLE after FIN.
    vh = '{32'h0000_0801, 32'h0000_0077, TAM_BYTE, 32'h0102_0304, 32'h0102_7704, 1'b0, 6, 1, 1};
    do_store(1'b1, vh, 6, 1'b1, "b_hold1");
    do_store(1'b1, vh, 6, 1'b0, "b_hold2");

    repeat (3) @(negedge clk);
    check("a_queue_drained", 64'(exp_q_a.size()), 64'h0);
    check("b_queue_drained", 64'(exp_q_b.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/store_merge_rmw.md
Name: store_merge_rmw

Overview:
- Write-side counterpart of the load-path extender: takes a 32-bit register value and stores its low byte, low halfword or full word into word-organised data memory.
- Sub-word stores use a read-modify-write sequence: read the containing word, merge the new lane, write the word back.
- Sits between the datapath store port and the data memory. The core stalls on busy.

Parameters:
- READ_LAT, 1: data-memory read latency in cycles, from the mem_rd_en cycle to the cycle mem_rdata is valid (range 1..4).
- ADDR_W, 32: byte-address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  store request, sampled only in IDLE.
- Direccion  input  ADDR_W  byte address of the store.
- Dato  input  32  register value to store; only the low lane is used for byte/half.
- Tamano  input  2  store size: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as error).
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when the operation completes.
- error  output  1  one-cycle pulse, coincident with done, for a misaligned or reserved request.
- mem_addr  output  ADDR_W  word-aligned address {Direccion[ADDR_W-1:2], 2'b00}.
- mem_rd_en  output  1  one-cycle read strobe.
- mem_rdata  input  32  read data from memory.
- mem_wr_en  output  1  one-cycle write strobe.
- mem_wdata  output  32  merged word to write.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE.
  - busy, done, error, mem_rd_en and mem_wr_en = 0.
  - mem_addr, mem_wdata and internal registers = 0.
  - Reset asserted mid-operation aborts the operation immediately; no write is issued afterwards.
- Request capture:
  - On a clk edge in IDLE with start = 1, latch Direccion, Dato and Tamano.
  - start is ignored while busy.
- Alignment check, at capture:
  - Half with Direccion[0] = 1 is an error.
  - Word with Direccion[1:0] != 0 is an error.
  - Tamano = 11 is an error.
  - On error: go to FIN with error = 1; no memory access is made.
- States:
  - IDLE.
  - LEER: mem_rd_en = 1 for exactly one cycle, mem_addr valid.
  - ESPERA: count READ_LAT cycles and capture mem_rdata in the final one. With READ_LAT = 1, ESPERA lasts 1 cycle and captures mem_rdata.
  - ESCRIBIR: mem_wr_en = 1 for one cycle, mem_wdata = merged word.
  - FIN: done = 1 for one cycle, then IDLE.
- Transitions:
  - IDLE to LEER for an aligned byte/half; IDLE to ESCRIBIR for an aligned word; IDLE to FIN on error.
  - LEER to ESPERA; ESPERA to ESCRIBIR when the count expires; ESCRIBIR to FIN; FIN to IDLE.
- Latency, counted from the start-accept edge to the done-high cycle:
  - Word: 2 cycles.
  - Byte/half: 3 + READ_LAT cycles.
  - Error: 1 cycle.
- Merge rule (little-endian, lane = Direccion[1:0]):
  - Byte: replace bits [8*lane+7 : 8*lane] with Dato[7:0]; the other bytes come from the captured read word.
  - Half: lane 0 replaces [15:0], lane 2 replaces [31:16], each with Dato[15:0].
  - Word: mem_wdata = Dato, no read.
- Output behaviour:
  - mem_addr is held stable from LEER through ESCRIBIR.
  - mem_rd_en and mem_wr_en are never high in the same cycle.
  - Both strobes are registered outputs.
- A new start in the FIN cycle is ignored. The earliest accepted back-to-back start is the cycle after FIN, which is IDLE.

Decomposition:
- Shared package holds:
  - Size encodings TAM_BYTE = 2'b00, TAM_HALF = 2'b01, TAM_WORD = 2'b10.
  - FSM state enum {IDLE, LEER, ESPERA, ESCRIBIR, FIN}.
- One natural combinational sub-module: lane_merge. Inputs: old word, Dato, Tamano, lane. Output: merged word. It is reusable by a future cache write path.

Test Plan:
- Byte store: mem word 0x11223344, start byte, Direccion = 0x101, Dato = 0xFFFFFFAB -> one mem_rd_en at mem_addr = 0x100, then mem_wr_en with mem_wdata = 0x1122AB44; done 4 cycles after accept (READ_LAT = 1); error = 0.
- Half store: mem word 0xDEADBEEF, Direccion = 0x202, Dato = 0x00001234 -> mem_wdata = 0x1234BEEF.
- Word store: Direccion = 0x300, Dato = 0xCAFEF00D -> no mem_rd_en; mem_wr_en next cycle with 0xCAFEF00D; done 2 cycles after accept.
- Misaligned: half at 0x203, then word at 0x302 -> no strobes; done = error = 1 one cycle after accept for each.
- Reset mid-operation: drop rst_n while in ESPERA -> all outputs 0 immediately, no mem_wr_en after release; a new byte store then completes normally.
- READ_LAT = 3 with start held high through busy -> exactly one operation; done 6 cycles after accept; second operation accepted only after FIN.
